// File: rtl/dmi_wb_arbiter.sv
// dmi_wb_arbiter: two-master to one-slave Wishbone arbiter in front of the
// debug module. Master 0 is the JTAG DTM path after the async_reg_wb CDC, and
// master 1 is a secondary debugger port such as a UART debug bridge.
//
// Arbitration is round-robin at transaction granularity. A grant is taken
// one cycle after a request is seen, and it is held for the whole CYC. At
// least one idle cycle separates two consecutive grants.
//
// Handshake: a master requests with CYC&STB. While it holds the grant, its
// STB, ADR, DAT, WE and SEL pass combinationally to the slave, and the
// slave's ACK/ERR return only to that master, qualified by the forwarded CYC.
// A master releases the bus by dropping CYC. An ACK or ERR that arrives after
// the release, or while the arbiter is idle, goes to no master.
//
// Optional feature (macro DMI_ARB_TIMEOUT_EN): a stall watchdog. After
// TIMEOUT_CYCLES stalled strobe cycles it sends the granted master a single
// ERR pulse. It then holds s_cyc_o/s_stb_o low until that master drops CYC.
// Without the macro a stalled slave holds the grant indefinitely.
//
// FSM state is observable through busy_o (1 in GNT) and grant_o (owner).

module dmi_wb_arbiter #(
  parameter int ADDRW          = 8,
  parameter int DATAW          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  // master side
  input  logic [2*ADDRW-1:0]     m_adr_i,
  input  logic [2*DATAW-1:0]     m_dat_i,
  output logic [DATAW-1:0]       m_dat_o,
  input  logic [1:0]             m_we_i,
  input  logic [2*(DATAW/8)-1:0] m_sel_i,
  input  logic [1:0]             m_cyc_i,
  input  logic [1:0]             m_stb_i,
  output logic [1:0]             m_ack_o,
  output logic [1:0]             m_err_o,
  // slave side
  output logic [ADDRW-1:0]       s_adr_o,
  output logic [DATAW-1:0]       s_dat_o,
  input  logic [DATAW-1:0]       s_dat_i,
  output logic                   s_we_o,
  output logic [DATAW/8-1:0]     s_sel_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  // status
  output logic [1:0]             grant_o,
  output logic                   busy_o
);

  localparam int SELW = DATAW / 8;

  typedef enum logic {
    IDLE = 1'b0,
    GNT  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  // Index of the master granted most recently. It resets to 1 so that
  // master 0 wins the first tie.
  logic        last_q, last_d;

  logic [1:0]  req;
  logic        busy;
  logic        g;          // index of the granted master (0 while idle)
  logic        win;        // index of the master chosen in IDLE
  logic        release_c;  // granted master drops CYC this cycle

  logic        abort_q;    // watchdog has fired, slave strobes are suppressed
  logic        to_pulse_q; // one-cycle ERR pulse after a watchdog expiry

  assign req       = m_cyc_i & m_stb_i;
  assign busy      = (state_q == GNT);
  assign g         = grant_q[1];
  assign release_c = busy & ~m_cyc_i[g];

  assign grant_o = grant_q;
  assign busy_o  = busy;

  // ---------------------------------------------------------------------
  // Arbitration FSM
  // ---------------------------------------------------------------------

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic: pick a winner in IDLE, hold the grant until CYC drops.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    win     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          // On a tie the master that did not hold the last grant wins.
          if (req == 2'b11) win = ~last_q;
          else              win = req[1];
          state_d = GNT;
          grant_d = win ? 2'b10 : 2'b01;
          last_d  = win;
        end
      end
      GNT: begin
        if (!m_cyc_i[g]) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Data path
  // ---------------------------------------------------------------------

  // Forward the granted master's fields to the slave. While idle g is 0, so
  // master 0's fields are driven.
  always_comb begin
    s_adr_o = m_adr_i[ADDRW*g +: ADDRW];
    s_dat_o = m_dat_i[DATAW*g +: DATAW];
    s_sel_o = m_sel_i[SELW*g  +: SELW];
    s_we_o  = m_we_i[g];
  end

  assign s_cyc_o = busy & m_cyc_i[g] & ~abort_q;
  assign s_stb_o = busy & m_stb_i[g] & ~abort_q;
  assign m_dat_o = s_dat_i;

  // Route the slave response to the granted master only.
  always_comb begin
    m_ack_o    = 2'b00;
    m_err_o    = 2'b00;
    m_ack_o[g] = s_ack_i & s_cyc_o;
    m_err_o[g] = (s_err_i & s_cyc_o) | to_pulse_q;
  end

  // ---------------------------------------------------------------------
  // Stall watchdog
  // ---------------------------------------------------------------------
`ifdef DMI_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        abort_d;
  logic        to_pulse_d;
  logic        stall;

  assign stall = s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i;

  // Watchdog registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wd_cnt_q   <= '0;
      abort_q    <= 1'b0;
      to_pulse_q <= 1'b0;
    end else begin
      wd_cnt_q   <= wd_cnt_d;
      abort_q    <= abort_d;
      to_pulse_q <= to_pulse_d;
    end
  end

  // Count stalled strobe cycles. On expiry, fire one ERR pulse and abort
  // until the granted master releases the bus.
  always_comb begin
    wd_cnt_d   = wd_cnt_q;
    abort_d    = abort_q;
    to_pulse_d = 1'b0;
    if (stall) begin
      if (wd_cnt_q + 16'd1 == TO_LIMIT) begin
        wd_cnt_d   = '0;
        abort_d    = 1'b1;
        to_pulse_d = 1'b1;
      end else begin
        wd_cnt_d = wd_cnt_q + 16'd1;
      end
    end else if (!busy || abort_q || s_ack_i || s_err_i) begin
      wd_cnt_d = '0;
    end
    if (release_c) begin
      abort_d  = 1'b0;
      wd_cnt_d = '0;
    end
  end
`else
  assign abort_q    = 1'b0;
  assign to_pulse_q = 1'b0;
`endif

endmodule

// File: tb/tb_dmi_wb_arbiter.sv
// tb_dmi_wb_arbiter: directed scenarios followed by randomized traffic on
// both masters. Each cycle is compared against a bus-ownership reference
// model.

module tb_dmi_wb_arbiter;

  localparam int ADDRW = 8;
  localparam int DATAW = 32;
  localparam int TO    = 4;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                 rst_n_i;
  logic [2*ADDRW-1:0]   m_adr_i;
  logic [2*DATAW-1:0]   m_dat_i;
  logic [DATAW-1:0]     m_dat_o;
  logic [1:0]           m_we_i;
  logic [2*DATAW/8-1:0] m_sel_i;
  logic [1:0]           m_cyc_i, m_stb_i, m_ack_o, m_err_o;
  logic [ADDRW-1:0]     s_adr_o;
  logic [DATAW-1:0]     s_dat_o, s_dat_i;
  logic                 s_we_o;
  logic [DATAW/8-1:0]   s_sel_o;
  logic                 s_cyc_o, s_stb_o, s_ack_i, s_err_i;
  logic [1:0]           grant_o;
  logic                 busy_o;

  dmi_wb_arbiter #(.ADDRW(ADDRW), .DATAW(DATAW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_we_i(m_we_i),
    .m_sel_i(m_sel_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // owner: -1 when nobody holds the bus, else the master index.
  int owner   = -1;
  int last_w  = 1;
  bit aborted = 1'b0;
  bit pulse   = 1'b0;
  int stalls  = 0;
  bit exp_scyc, exp_sstb;

  // Compare every output against the model for the present cycle.
  task automatic check_cycle(input string tag);
    int m;
    logic [1:0] e_grant, e_ack, e_err;
    logic [46:0] e_slv, a_slv;
    m        = (owner < 0) ? 0 : owner;
    e_grant  = (owner < 0) ? 2'b00 : 2'(1 << owner);
    exp_scyc = (owner >= 0) && m_cyc_i[m] && !aborted;
    exp_sstb = (owner >= 0) && m_stb_i[m] && !aborted;
    e_ack    = (exp_scyc && s_ack_i) ? 2'(1 << m) : 2'b00;
    e_err    = ((exp_scyc && s_err_i) || pulse) ? 2'(1 << m) : 2'b00;
    e_slv    = {exp_scyc, exp_sstb, m_we_i[m], m_sel_i[m*4 +: 4],
                m_adr_i[m*8 +: 8], m_dat_i[m*32 +: 32]};
    a_slv    = {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o};
    check({tag, "_grant"}, {grant_o, busy_o}, {e_grant, owner >= 0});
    check({tag, "_slave"}, a_slv, e_slv);
    check({tag, "_resp"},  {m_ack_o, m_err_o}, {e_ack, e_err});
    check({tag, "_rdat"},  m_dat_o, s_dat_i);
  endtask

  // Advance the model by one clock edge using the inputs held at that edge.
  task automatic model_edge();
    bit nxt_pulse;
    logic [1:0] req;
    if (!rst_n_i) begin
      owner = -1; last_w = 1; aborted = 0; pulse = 0; stalls = 0;
      return;
    end
    nxt_pulse = 0;
`ifdef DMI_ARB_TIMEOUT_EN
    if (owner >= 0 && exp_scyc && exp_sstb && !s_ack_i && !s_err_i) begin
      stalls++;
      if (stalls == TO) begin nxt_pulse = 1; aborted = 1; stalls = 0; end
    end else if (owner < 0 || aborted || s_ack_i || s_err_i) begin
      stalls = 0;
    end
`endif
    req = m_cyc_i & m_stb_i;
    if (owner < 0) begin
      if (req == 2'b11)      owner = 1 - last_w;
      else if (req == 2'b01) owner = 0;
      else if (req == 2'b10) owner = 1;
      if (owner >= 0) last_w = owner;
    end else if (!m_cyc_i[owner]) begin
      owner = -1; aborted = 0; stalls = 0;
    end
    pulse = nxt_pulse;
  endtask

  // One cycle: settle, check, clock, update model.
  task automatic step(input string tag);
    #1;
    check_cycle(tag);
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_m(input int i, input bit cyc, input bit stb, input bit we,
                       input logic [7:0] adr, input logic [31:0] dat);
    m_cyc_i[i]       = cyc;
    m_stb_i[i]       = stb;
    m_we_i[i]        = we;
    m_adr_i[i*8 +: 8]   = adr;
    m_dat_i[i*32 +: 32] = dat;
    m_sel_i[i*4 +: 4]   = 4'hF;
  endtask

  task automatic slave(input bit ack, input bit err, input logic [31:0] dat);
    s_ack_i = ack; s_err_i = err; s_dat_i = dat;
  endtask

  task automatic rand_cycle();
    for (int i = 0; i < 2; i++) begin
      if (!m_cyc_i[i]) begin
        if ($urandom_range(0, 9) < 3)
          set_m(i, 1, 1, 1'($urandom), 8'($urandom), $urandom);
      end else if ($urandom_range(0, 9) < 2) begin
        m_cyc_i[i] = 0; m_stb_i[i] = 0;
      end else begin
        m_stb_i[i] = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 3) == 0) m_adr_i[i*8 +: 8] = 8'($urandom);
      end
    end
    m_sel_i[3:0] = 4'($urandom);
    slave($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom);
    rst_n_i = ($urandom_range(0, 99) != 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n_i = 0;
    m_adr_i = '0; m_dat_i = '0; m_we_i = '0; m_sel_i = '0;
    m_cyc_i = '0; m_stb_i = '0;
    slave(0, 0, 32'h0);
    @(posedge clk_i); model_edge(); #1;
    step("reset");
    rst_n_i = 1;

    // m0 write, slave acks two cycles after the strobe appears
    set_m(0, 1, 1, 1, 8'h10, 32'h0000_0001);
    step("wr_req");
    step("wr_wait");
    slave(1, 0, 32'h0);
    step("wr_ack");
    slave(0, 0, 32'h0); set_m(0, 0, 0, 0, 8'h00, 32'h0);
    step("wr_rel");
    step("wr_idle");

    // tie on the same edge: m0 first, then m1, next tie back to m0
    set_m(0, 1, 1, 0, 8'h20, 32'h0); set_m(1, 1, 1, 0, 8'h21, 32'h0);
    step("tie_req");
    slave(1, 0, 32'h1234_5678);
    step("tie_m0");
    slave(0, 0, 32'h0); m_cyc_i[0] = 0; m_stb_i[0] = 0;
    step("tie_rel0");
    step("tie_bubble");
    slave(1, 0, 32'hCAFE_F00D);
    step("tie_m1");
    slave(0, 0, 32'h0); m_cyc_i[1] = 0; m_stb_i[1] = 0;
    step("tie_rel1");
    set_m(0, 1, 1, 0, 8'h30, 32'h0); set_m(1, 1, 1, 0, 8'h31, 32'h0);
    step("tie2_req");
    step("tie2_m0");
    set_m(0, 0, 0, 0, 8'h00, 32'h0); set_m(1, 0, 0, 0, 8'h00, 32'h0);
    step("tie2_rel");
    step("tie2_idle");

    // m1 read while m0 waits: only m1 sees the ack
    set_m(1, 1, 1, 0, 8'h11, 32'h0);
    step("rd_req");
    set_m(0, 1, 1, 1, 8'h40, 32'h5);
    slave(1, 0, 32'hDEAD_BEEF);
    step("rd_ack");
    slave(0, 0, 32'h0); m_cyc_i[1] = 0; m_stb_i[1] = 0;
    step("rd_rel");
    step("rd_bubble");
    step("rd_m0");
    set_m(0, 0, 0, 0, 8'h00, 32'h0);
    step("rd_done");

    // m0 abandons a stalled access; the late ack goes nowhere
    set_m(0, 1, 1, 0, 8'h50, 32'h0);
    step("ab_req");
    step("ab_stall");
    set_m(0, 0, 0, 0, 8'h50, 32'h0);
    step("ab_drop");
    step("ab_idle");
    slave(1, 0, 32'h0);
    step("ab_late_ack");
    slave(0, 0, 32'h0);

`ifdef DMI_ARB_TIMEOUT_EN
    // slave never answers: watchdog fires, grant held until CYC drops
    set_m(0, 1, 1, 0, 8'h60, 32'h0);
    for (int k = 0; k < 9; k++) step("wd_stall");
    slave(1, 0, 32'h0);
    step("wd_ack_ignored");
    slave(0, 0, 32'h0); set_m(0, 0, 0, 0, 8'h00, 32'h0);
    step("wd_rel");
    step("wd_idle");
`endif

    // reset in the middle of a granted m1 transfer
    set_m(1, 1, 1, 1, 8'h70, 32'h7);
    step("rst_req");
    step("rst_m1");
    rst_n_i = 0; slave(1, 0, 32'h0);
    step("rst_hit");
    rst_n_i = 1; slave(0, 0, 32'h0);
    set_m(0, 1, 1, 0, 8'h71, 32'h0);
    step("rst_tie");
    step("rst_tie_m0");
    set_m(0, 0, 0, 0, 8'h00, 32'h0); set_m(1, 0, 0, 0, 8'h00, 32'h0);
    step("rst_end");

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rand_cycle();
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
